// File: rtl/greyscale_fb_reader.sv
// greyscale_fb_reader: frame-buffer read side. Fetches packed luma
// words from BRAM and emits one raster-ordered pixel per valid/ready beat.
// Ports: clk_pixel, rst_in (sync, active-high), start_in (frame start),
//   addr_out/bram_data_in (BRAM read port), pixel_out/hcount_out/
//   vcount_out/valid_out/ready_in (pixel stream), frame_done_out, busy_out.
// Option: GREYSCALE_FB_TESTPAT_EN adds testpat_in, which replaces the
//   pixel with (hcount + vcount) mod 256 on any beat where it is high.
module greyscale_fb_reader #(
  parameter int WIDTH           = 320,
  parameter int HEIGHT          = 240,
  parameter int PIXELS_PER_WORD = 6,
  parameter int BRAM_LATENCY    = 2
) (
  input  logic                         clk_pixel,
  input  logic                         rst_in,
  input  logic                         start_in,
`ifdef GREYSCALE_FB_TESTPAT_EN
  input  logic                         testpat_in,
`endif
  output logic [16:0]                  addr_out,
  input  logic [8*PIXELS_PER_WORD-1:0] bram_data_in,
  output logic [7:0]                   pixel_out,
  output logic [8:0]                   hcount_out,
  output logic [7:0]                   vcount_out,
  output logic                         valid_out,
  input  logic                         ready_in,
  output logic                         frame_done_out,
  output logic                         busy_out
);

  localparam int WW    = 8 * PIXELS_PER_WORD;
  localparam int WORDS = WIDTH * HEIGHT / PIXELS_PER_WORD;
  localparam int SW    =
    (PIXELS_PER_WORD > 1) ? $clog2(PIXELS_PER_WORD) : 1;

  localparam logic [16:0]   LAST = 17'(WORDS - 1);
  localparam logic [8:0]    HMAX = 9'(WIDTH - 1);
  localparam logic [7:0]    VMAX = 8'(HEIGHT - 1);
  localparam logic [SW-1:0] SMAX = SW'(PIXELS_PER_WORD - 1);

  if ((WIDTH * HEIGHT) % PIXELS_PER_WORD != 0) begin : g_bad_geom
    $error("WIDTH*HEIGHT must be a multiple of PIXELS_PER_WORD");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state;
  logic [16:0]           next_addr;
  logic [16:0]           cur_addr;
  // sr[k] marks a read whose address has been visible for k+1 cycles;
  // sr[BRAM_LATENCY] is the word on bram_data_in this cycle.
  logic [BRAM_LATENCY:0] sr;
  logic [WW-1:0]         fifo_mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;
  logic [SW-1:0]         sub;
  logic [3:0]            in_flight;
  logic [WW-1:0]         head;
  logic [7:0]            pix;
  logic                  iss;
  logic                  last_iss;
  logic                  push;
  logic                  pop;
  logic                  acc;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i <= BRAM_LATENCY; i++)
      in_flight = in_flight + 4'(sr[i]);
  end

  // A fresh frame always starts at word 0, so the start cycle itself
  // can issue; this keeps first-pixel latency at BRAM_LATENCY+2.
  assign cur_addr = (state == IDLE) ? '0 : next_addr;
  assign iss = ((state == RUN) || (state == IDLE && start_in))
            && (({2'b00, count} + in_flight) < 4'd2);
  assign last_iss = iss && (cur_addr == LAST);

  assign push      = sr[BRAM_LATENCY];
  assign valid_out = (count != 2'd0);
  assign acc       = valid_out && ready_in;
  assign pop       = acc && (sub == SMAX);
  assign head      = fifo_mem[rd_ptr];
  assign busy_out  = (state != IDLE);

  // Oldest pixel sits in the top byte of the word.
  always_comb begin
    pix = '0;
    for (int i = 0; i < PIXELS_PER_WORD; i++)
      if (sub == SW'(i)) pix = head[WW-1-8*i -: 8];
  end

  always_comb begin
    pixel_out = '0;
    if (valid_out) begin
`ifdef GREYSCALE_FB_TESTPAT_EN
      if (testpat_in)
        pixel_out = hcount_out[7:0] + vcount_out;
      else
        pixel_out = pix;
`else
      pixel_out = pix;
`endif
    end
  end

  assign frame_done_out = acc
                       && (hcount_out == HMAX)
                       && (vcount_out == VMAX);

  always_ff @(posedge clk_pixel) begin
    if (rst_in) begin
      state       <= IDLE;
      addr_out    <= '0;
      next_addr   <= '0;
      sr          <= '0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= '0;
      sub         <= '0;
      hcount_out  <= '0;
      vcount_out  <= '0;
    end else begin
      sr <= {sr[BRAM_LATENCY-1:0], iss};
      if (iss) begin
        addr_out  <= cur_addr;
        next_addr <= cur_addr + 17'd1;
      end
      if (push) begin
        fifo_mem[wr_ptr] <= bram_data_in;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (acc) begin
        sub <= (sub == SMAX) ? '0 : sub + SW'(1);
        if (hcount_out == HMAX) begin
          hcount_out <= '0;
          vcount_out <= (vcount_out == VMAX)
                      ? '0 : vcount_out + 8'd1;
        end else begin
          hcount_out <= hcount_out + 9'd1;
        end
      end
      unique case (state)
        IDLE: if (start_in) begin
          state      <= last_iss ? DRAIN : RUN;
          hcount_out <= '0;
          vcount_out <= '0;
          sub        <= '0;
        end
        RUN:     if (last_iss) state <= DRAIN;
        DRAIN:   if (frame_done_out) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_greyscale_fb_reader.sv
// tb_greyscale_fb_reader: directed bench for greyscale_fb_reader with
// a behavioural two-cycle BRAM holding pixel value p%256 at index p.
module tb_greyscale_fb_reader;

  localparam int NPIX = 76800;
  localparam int LASTB = NPIX - 1;

  logic        clk_pixel = 1'b0;
  logic        rst_in = 1'b1;
  logic        start_in = 1'b0;
  logic        ready_in = 1'b0;
  logic [16:0] addr_out;
  logic [47:0] bram_data_in;
  logic [7:0]  pixel_out;
  logic [8:0]  hcount_out;
  logic [7:0]  vcount_out;
  logic        valid_out;
  logic        frame_done_out;
  logic        busy_out;
`ifdef GREYSCALE_FB_TESTPAT_EN
  logic        testpat_in = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  bit w0_special = 1'b0;

  always #5 clk_pixel = ~clk_pixel;

  greyscale_fb_reader dut (
    .clk_pixel      (clk_pixel),
    .rst_in         (rst_in),
    .start_in       (start_in),
`ifdef GREYSCALE_FB_TESTPAT_EN
    .testpat_in     (testpat_in),
`endif
    .addr_out       (addr_out),
    .bram_data_in   (bram_data_in),
    .pixel_out      (pixel_out),
    .hcount_out     (hcount_out),
    .vcount_out     (vcount_out),
    .valid_out      (valid_out),
    .ready_in       (ready_in),
    .frame_done_out (frame_done_out),
    .busy_out       (busy_out)
  );

  function automatic logic [7:0] exp_pix(input int p);
    if (w0_special && p < 6) return 8'(8'h0A + p);
    return 8'(p % 256);
  endfunction

  function automatic logic [47:0] word(input logic [16:0] a);
    logic [47:0] w;
    w = '0;
    for (int i = 0; i < 6; i++)
      w[47-8*i -: 8] = exp_pix(int'(a) * 6 + i);
    return w;
  endfunction

  logic [47:0] pipe0, pipe1;
  always @(posedge clk_pixel) begin
    pipe0 <= word(addr_out);
    pipe1 <= pipe0;
  end
  assign bram_data_in = pipe1;

  task automatic pulse_start();
    start_in = 1'b1;
    @(posedge clk_pixel); #1;
    start_in = 1'b0;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    @(posedge clk_pixel); #1;
    rst_in = 1'b0;
  endtask

  task automatic test_stream(input int duty, input int nbeats,
                             input bit poke, output int fdn);
    int beats, cyc, budget;
    bit stall, seen;
    logic [7:0] ppix, ep;
    logic [8:0] ph;
    logic [7:0] pv;
    logic [16:0] paddr;
    logic efd;
    beats = 0; cyc = 0; fdn = 0;
    stall = 1'b0; seen = 1'b0;
    ppix = '0; ph = '0; pv = '0; paddr = '0;
    budget = nbeats * ((duty == 100) ? 1 : 10) + 100;
    ready_in = (duty == 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
    while (beats < nbeats) begin
      @(negedge clk_pixel);
      cyc++;
      if (cyc > budget) begin
        tests++; fails++;
        $display("FAIL stream_timeout beats=%0d want %0d",
                 beats, nbeats);
        break;
      end
      if (stall) begin
        tests++;
        if (valid_out !== 1'b1 || pixel_out !== ppix ||
            hcount_out !== ph || vcount_out !== pv) begin
          fails++;
          $display("FAIL stall_hold v=%b px=%h (%0d,%0d) want px=%h (%0d,%0d)",
                   valid_out, pixel_out, hcount_out, vcount_out,
                   ppix, ph, pv);
        end
      end
      if (duty == 100 && seen) begin
        tests++;
        if (valid_out !== 1'b1) begin
          fails++;
          $display("FAIL no_gap beat=%0d valid=%b want 1",
                   beats, valid_out);
        end
      end
      if (valid_out === 1'b1) begin
        seen = 1'b1;
        ep = exp_pix(beats);
`ifdef GREYSCALE_FB_TESTPAT_EN
        if (testpat_in)
          ep = 8'(beats % 320) + 8'(beats / 320);
`endif
        tests++;
        if (pixel_out !== ep ||
            hcount_out !== 9'(beats % 320) ||
            vcount_out !== 8'(beats / 320)) begin
          fails++;
          if (fails < 20)
            $display("FAIL pixel beat=%0d got %h (%0d,%0d) want %h (%0d,%0d)",
                     beats, pixel_out, hcount_out, vcount_out,
                     ep, beats % 320, beats / 320);
        end
      end
      efd = (valid_out === 1'b1) && ready_in && (beats == LASTB);
      tests++;
      if (frame_done_out !== efd) begin
        fails++;
        $display("FAIL frame_done beat=%0d got %b want %b",
                 beats, frame_done_out, efd);
      end
      tests++;
      if (int'(addr_out) + 1 - beats / 6 > 2) begin
        fails++;
        if (fails < 20)
          $display("FAIL credit addr=%0d beats=%0d outstanding>2",
                   addr_out, beats);
      end
      if (addr_out !== paddr) begin
        tests++;
        if (addr_out !== paddr + 17'd1) begin
          fails++;
          if (fails < 20)
            $display("FAIL addr_seq got %0d want %0d",
                     addr_out, paddr + 17'd1);
        end
        paddr = addr_out;
      end
      stall = (valid_out === 1'b1) && !ready_in;
      ppix = pixel_out; ph = hcount_out; pv = vcount_out;
      if (valid_out === 1'b1 && ready_in) begin
        beats++;
        fdn += int'(frame_done_out);
      end
      @(posedge clk_pixel); #1;
      ready_in = (duty == 100) ? 1'b1
               : ($urandom_range(0, 99) < duty);
      start_in = poke && (beats == 5000 || beats == LASTB);
`ifdef GREYSCALE_FB_TESTPAT_EN
      testpat_in = poke && (beats == 1610 || beats == 64300);
`endif
    end
    start_in = 1'b0;
`ifdef GREYSCALE_FB_TESTPAT_EN
    testpat_in = 1'b0;
`endif
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    repeat (3) @(posedge clk_pixel);
    #1 rst_in = 1'b0;
    @(negedge clk_pixel);
    tests++;
    if (addr_out !== '0 || pixel_out !== '0) begin
      fails++;
      $display("FAIL reset_data addr=%h px=%h want 0 0",
               addr_out, pixel_out);
    end
    tests++;
    if (hcount_out !== '0 || vcount_out !== '0) begin
      fails++;
      $display("FAIL reset_coord h=%0d v=%0d want 0 0",
               hcount_out, vcount_out);
    end
    tests++;
    if (valid_out !== 1'b0 || frame_done_out !== 1'b0 ||
        busy_out !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctl v=%b fd=%b busy=%b want 0 0 0",
               valid_out, frame_done_out, busy_out);
    end
    @(posedge clk_pixel); #1;
  endtask

  task automatic test_first_word();
    int k;
    bit got;
    w0_special = 1'b1;
    ready_in = 1'b1;
    pulse_start();
    got = 1'b0;
    k = 0;
    while (k < 10 && !got) begin
      @(negedge clk_pixel);
      if (valid_out === 1'b1) got = 1'b1;
      else k++;
    end
    tests++;
    if (!got || k + 1 < 3 || k + 1 > 4) begin
      fails++;
      $display("FAIL latency got %0d cycles want 3..4", k + 1);
    end
    if (got) begin
      for (int i = 0; i < 6; i++) begin
        tests++;
        if (pixel_out !== 8'(8'h0A + i) ||
            hcount_out !== 9'(i) || valid_out !== 1'b1) begin
          fails++;
          $display("FAIL first_word beat=%0d got %h h=%0d want %h h=%0d",
                   i, pixel_out, hcount_out, 8'(8'h0A + i), i);
        end
        @(posedge clk_pixel); #1;
        @(negedge clk_pixel);
      end
    end
    @(posedge clk_pixel); #1;
    do_reset();
    w0_special = 1'b0;
  endtask

  task automatic test_stall();
    int fd;
    pulse_start();
    test_stream(30, 1200, 1'b0, fd);
    tests++;
    if (fd != 0) begin
      fails++;
      $display("FAIL stall_done got %0d pulses want 0", fd);
    end
    do_reset();
  endtask

  task automatic test_reset_mid();
    int fd;
    pulse_start();
    test_stream(100, 1000, 1'b0, fd);
    do_reset();
    @(negedge clk_pixel);
    tests++;
    if ({addr_out, pixel_out, hcount_out, vcount_out,
         valid_out, frame_done_out, busy_out} !== '0) begin
      fails++;
      $display("FAIL mid_reset addr=%0d px=%h (%0d,%0d) v=%b fd=%b b=%b want all 0",
               addr_out, pixel_out, hcount_out, vcount_out,
               valid_out, frame_done_out, busy_out);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_pixel); #1;
      @(negedge clk_pixel);
      tests++;
      if (valid_out !== 1'b0 || busy_out !== 1'b0) begin
        fails++;
        $display("FAIL late_data cyc=%0d v=%b b=%b want 0 0",
                 i, valid_out, busy_out);
      end
    end
    pulse_start();
    @(negedge clk_pixel);
    tests++;
    if (addr_out !== '0 || busy_out !== 1'b1) begin
      fails++;
      $display("FAIL replay_start addr=%0d busy=%b want 0 1",
               addr_out, busy_out);
    end
    @(posedge clk_pixel); #1;
    test_stream(100, 700, 1'b0, fd);
    do_reset();
  endtask

  task automatic test_full_frame();
    int fd;
    pulse_start();
    test_stream(100, NPIX, 1'b1, fd);
    tests++;
    if (fd != 1) begin
      fails++;
      $display("FAIL done_count got %0d want 1", fd);
    end
    start_in = 1'b1;
    @(negedge clk_pixel);
    tests++;
    if (busy_out !== 1'b0 || valid_out !== 1'b0 ||
        addr_out !== 17'd12799) begin
      fails++;
      $display("FAIL after_done b=%b v=%b addr=%0d want 0 0 12799",
               busy_out, valid_out, addr_out);
    end
    @(posedge clk_pixel); #1;
    start_in = 1'b0;
    @(negedge clk_pixel);
    tests++;
    if (busy_out !== 1'b1 || addr_out !== '0) begin
      fails++;
      $display("FAIL restart b=%b addr=%0d want 1 0",
               busy_out, addr_out);
    end
    @(posedge clk_pixel); #1;
    do_reset();
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_stall();
    test_reset_mid();
    test_full_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
